// File: rtl/spi_ram_pkg.sv
// Shared definitions for the SPI-attached RAM: command opcodes and FSM state encoding.
package spi_ram_pkg;

  localparam int OPCODE_W = 2;

  typedef enum logic [OPCODE_W-1:0] {
    CMD_WR_ADDR = 2'b00,
    CMD_WR_DATA = 2'b01,
    CMD_RD_ADDR = 2'b10,
    CMD_RD_DATA = 2'b11
  } cmd_e;

  typedef enum logic {
    S_IDLE    = 1'b0,
    S_TX_HOLD = 1'b1
  } state_e;

endpackage

// File: rtl/spi_ram_ram.sv
// Single-port synchronous RAM with registered read; a write cycle leaves the read register untouched.
module ram_sp_sync #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 256,
  parameter int AW    = (DEPTH > 1) ? $clog2(DEPTH) : 1
) (
  input  logic             clk,
  input  logic             we,
  input  logic             re,
  input  logic [AW-1:0]    addr,
  input  logic [WIDTH-1:0] wdata,
  output logic [WIDTH-1:0] rdata
);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [WIDTH-1:0] rdata_q;

  always_ff @(posedge clk) begin
    if (we) begin
      mem_q[addr] <= wdata;
    end else if (re) begin
      rdata_q <= mem_q[addr];
    end
  end

  assign rdata = rdata_q;

endmodule

// File: rtl/spi_ram.sv
// Command-driven RAM behind an SPI slave: address/data commands, auto-incrementing bursts,
// and a read path that holds dout/tx_valid for TX_HOLD cycles while the serializer shifts it out.
module spi_ram
  import spi_ram_pkg::*;
#(
  parameter int DATA_SIZE = 8,
  parameter int MEM_DEPTH = 256,
  parameter int TX_HOLD   = 10
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic [DATA_SIZE+1:0] din,
  input  logic                 rx_valid,
  output logic [DATA_SIZE-1:0] dout,
  output logic                 tx_valid,
  output logic                 cmd_err
);

  localparam int AW = (MEM_DEPTH > 1) ? $clog2(MEM_DEPTH) : 1;
  localparam int CW = (TX_HOLD > 0) ? $clog2(TX_HOLD + 1) : 1;
  localparam logic [AW-1:0] ADDR_LAST = AW'(MEM_DEPTH - 1);
  localparam logic [CW-1:0] HOLD_LOAD = CW'(TX_HOLD);

  function automatic logic [AW-1:0] to_addr(input logic [DATA_SIZE-1:0] p);
    return AW'(32'(p) % 32'(MEM_DEPTH));
  endfunction

  function automatic logic [AW-1:0] next_addr(input logic [AW-1:0] a);
    return (a == ADDR_LAST) ? '0 : a + AW'(1);
  endfunction

  state_e               state_q, state_d;
  logic [CW-1:0]        cnt_q, cnt_d;
  logic [DATA_SIZE-1:0] dout_q, dout_d;
  logic                 tx_valid_q, tx_valid_d;
  logic                 cmd_err_q, cmd_err_d;
  logic [AW-1:0]        wr_addr_q, wr_addr_d;
  logic [AW-1:0]        rd_addr_q, rd_addr_d;
  logic                 wr_vld_q, wr_vld_d;
  logic                 rd_vld_q, rd_vld_d;
  logic                 rx_prev_q, rx_prev_d;

  logic                 accept;
  cmd_e                 op;
  logic [DATA_SIZE-1:0] payload;
  logic                 ram_we, ram_re;
  logic [AW-1:0]        ram_addr;
  logic [DATA_SIZE-1:0] ram_rdata;

  assign accept  = rx_valid & ~rx_prev_q;
  assign op      = cmd_e'(din[DATA_SIZE+1:DATA_SIZE]);
  assign payload = din[DATA_SIZE-1:0];

  ram_sp_sync #(
    .WIDTH (DATA_SIZE),
    .DEPTH (MEM_DEPTH),
    .AW    (AW)
  ) u_ram (
    .clk   (clk),
    .we    (ram_we),
    .re    (ram_re),
    .addr  (ram_addr),
    .wdata (payload),
    .rdata (ram_rdata)
  );

  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    dout_d     = dout_q;
    tx_valid_d = 1'b0;
    cmd_err_d  = 1'b0;
    wr_addr_d  = wr_addr_q;
    rd_addr_d  = rd_addr_q;
    wr_vld_d   = wr_vld_q;
    rd_vld_d   = rd_vld_q;
    rx_prev_d  = rx_valid;
    ram_we     = 1'b0;
    ram_re     = 1'b0;
    ram_addr   = wr_addr_q;

    // RAM read data lands one cycle after acceptance; capture it once, at the full count.
    if (state_q == S_TX_HOLD) begin
      if (cnt_q == '0) begin
        state_d = S_IDLE;
      end else begin
        tx_valid_d = 1'b1;
        cnt_d      = cnt_q - CW'(1);
        if (cnt_q == HOLD_LOAD) begin
          dout_d = ram_rdata;
        end
      end
    end

    if (accept) begin
      case (op)
        CMD_WR_ADDR: begin
          wr_addr_d = to_addr(payload);
          wr_vld_d  = 1'b1;
        end
        CMD_WR_DATA: begin
          if (wr_vld_q) begin
            ram_we    = 1'b1;
            ram_addr  = wr_addr_q;
            wr_addr_d = next_addr(wr_addr_q);
          end else begin
            cmd_err_d = 1'b1;
          end
        end
        CMD_RD_ADDR: begin
          rd_addr_d = to_addr(payload);
          rd_vld_d  = 1'b1;
        end
        CMD_RD_DATA: begin
          if (rd_vld_q && state_q == S_IDLE) begin
            ram_re    = 1'b1;
            ram_addr  = rd_addr_q;
            rd_addr_d = next_addr(rd_addr_q);
            state_d   = S_TX_HOLD;
            cnt_d     = HOLD_LOAD;
          end else begin
            cmd_err_d = 1'b1;
          end
        end
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q    <= S_IDLE;
      cnt_q      <= '0;
      dout_q     <= '0;
      tx_valid_q <= 1'b0;
      cmd_err_q  <= 1'b0;
      wr_addr_q  <= '0;
      rd_addr_q  <= '0;
      wr_vld_q   <= 1'b0;
      rd_vld_q   <= 1'b0;
      rx_prev_q  <= 1'b0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      dout_q     <= dout_d;
      tx_valid_q <= tx_valid_d;
      cmd_err_q  <= cmd_err_d;
      wr_addr_q  <= wr_addr_d;
      rd_addr_q  <= rd_addr_d;
      wr_vld_q   <= wr_vld_d;
      rd_vld_q   <= rd_vld_d;
      rx_prev_q  <= rx_prev_d;
    end
  end

  assign dout     = dout_q;
  assign tx_valid = tx_valid_q;
  assign cmd_err  = cmd_err_q;

endmodule

// File: tb/tb_spi_ram.sv
// Directed bench for spi_ram: a behavioural model predicts cmd_err and queues expected read data.
module tb_spi_ram;

  localparam int DS    = 8;
  localparam int DEPTH = 256;
  localparam int HOLD  = 10;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic [DS+1:0] din = '0;
  logic          rx_valid = 1'b0;
  logic [DS-1:0] dout;
  logic          tx_valid;
  logic          cmd_err;

  always #5 clk = ~clk;

  spi_ram #(
    .DATA_SIZE (DS),
    .MEM_DEPTH (DEPTH),
    .TX_HOLD   (HOLD)
  ) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .din      (din),
    .rx_valid (rx_valid),
    .dout     (dout),
    .tx_valid (tx_valid),
    .cmd_err  (cmd_err)
  );

  int checks = 0;
  int errors = 0;

  // reference model
  logic [DS-1:0] m_mem [DEPTH];
  int            m_wa = 0;
  int            m_ra = 0;
  bit            m_wv = 0;
  bit            m_rv = 0;
  bit            m_busy = 0;
  logic [DS-1:0] sb_q [$];

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    m_wa = 0;
    m_ra = 0;
    m_wv = 0;
    m_rv = 0;
    m_busy = 0;
    sb_q.delete();
  endtask

  // One command: rising rx_valid, accept edge, then one low edge so the next command re-arms.
  task automatic cmd(input string tag, input logic [1:0] op, input logic [DS-1:0] pl);
    bit exp_err;
    exp_err = 0;
    case (op)
      2'b00: begin m_wa = int'(pl) % DEPTH; m_wv = 1; end
      2'b01: begin
        if (m_wv) begin m_mem[m_wa] = pl; m_wa = (m_wa + 1) % DEPTH; end
        else exp_err = 1;
      end
      2'b10: begin m_ra = int'(pl) % DEPTH; m_rv = 1; end
      default: begin
        if (m_rv && !m_busy) begin
          sb_q.push_back(m_mem[m_ra]);
          m_ra = (m_ra + 1) % DEPTH;
          m_busy = 1;
        end else exp_err = 1;
      end
    endcase
    din = {op, pl};
    rx_valid = 1'b1;
    tick();
    chk({tag, "_err"}, 32'(cmd_err), 32'(exp_err));
    $display("cmd %s op=%0d payload=%02h cmd_err=%0b", tag, op, pl, cmd_err);
    rx_valid = 1'b0;
    tick();
    chk({tag, "_err_pulse"}, 32'(cmd_err), 32'd0);
  endtask

  // Consume one queued read: dout must match while tx_valid is high, for HOLD cycles in total.
  task automatic read_out(input string tag, input int pre);
    logic [DS-1:0] exp;
    int n;
    n = 0;
    exp = (sb_q.size() > 0) ? sb_q.pop_front() : '0;
    while (tx_valid === 1'b1 && n < 40) begin
      chk({tag, "_dout"}, 32'(dout), 32'(exp));
      n++;
      tick();
    end
    chk({tag, "_hold_len"}, 32'(n + pre), 32'(HOLD));
    chk({tag, "_tx_low"}, 32'(tx_valid), 32'd0);
    $display("read %s data=%02h cycles=%0d", tag, dout, n + pre);
    m_busy = 0;
  endtask

  initial begin
    // reset state
    rst_n = 1'b0;
    repeat (3) tick();
    chk("rst_dout", 32'(dout), 32'd0);
    chk("rst_tx_valid", 32'(tx_valid), 32'd0);
    chk("rst_cmd_err", 32'(cmd_err), 32'd0);
    rst_n = 1'b1;
    tick();
    model_reset();

    // basic write then read, 10-cycle hold
    cmd("wa10", 2'b00, 8'h10);
    cmd("wdA5", 2'b01, 8'hA5);
    cmd("ra10", 2'b10, 8'h10);
    cmd("rd_a5", 2'b11, 8'h00);
    read_out("rd_a5", 0);

    // write/read address wrap at MEM_DEPTH-1
    cmd("waFF", 2'b00, 8'hFF);
    cmd("wd11", 2'b01, 8'h11);
    cmd("wd22", 2'b01, 8'h22);
    cmd("raFF", 2'b10, 8'hFF);
    cmd("rd_ff", 2'b11, 8'h00);
    read_out("rd_ff", 0);
    cmd("rd_00", 2'b11, 8'h00);
    read_out("rd_00", 0);

    // rx_valid held high: a single write only
    cmd("wa50", 2'b00, 8'h50);
    m_mem[m_wa] = 8'h33;
    m_wa = (m_wa + 1) % DEPTH;
    din = {2'b01, 8'h33};
    rx_valid = 1'b1;
    for (int i = 0; i < 20; i++) tick();
    $display("cmd held_wd33 op=1 payload=33 cycles=20");
    rx_valid = 1'b0;
    tick();
    cmd("wd34", 2'b01, 8'h34);
    cmd("ra50", 2'b10, 8'h50);
    cmd("rd_50", 2'b11, 8'h00);
    read_out("rd_50", 0);
    cmd("rd_51", 2'b11, 8'h00);
    read_out("rd_51", 0);

    // RD_DATA during TX_HOLD is dropped
    cmd("wa40", 2'b00, 8'h40);
    cmd("wdC1", 2'b01, 8'hC1);
    cmd("wdC2", 2'b01, 8'hC2);
    cmd("ra40", 2'b10, 8'h40);
    cmd("rd_40", 2'b11, 8'h00);
    cmd("rd_busy", 2'b11, 8'h00);
    read_out("rd_40", 2);
    cmd("rd_41", 2'b11, 8'h00);
    read_out("rd_41", 0);

    // reset in the middle of a hold aborts the read
    cmd("ra10b", 2'b10, 8'h10);
    cmd("rd_abort", 2'b11, 8'h00);
    chk("abort_tx_pre", 32'(tx_valid), 32'd1);
    tick();
    rst_n = 1'b0;
    tick();
    chk("abort_tx_valid", 32'(tx_valid), 32'd0);
    chk("abort_dout", 32'(dout), 32'd0);
    model_reset();
    rst_n = 1'b1;
    tick();
    chk("post_rst_tx_valid", 32'(tx_valid), 32'd0);

    // data commands without an address are rejected; memory untouched
    cmd("wd_noaddr", 2'b01, 8'h99);
    cmd("rd_noaddr", 2'b11, 8'h00);
    chk("rd_noaddr_tx", 32'(tx_valid), 32'd0);
    tick();
    chk("rd_noaddr_tx2", 32'(tx_valid), 32'd0);
    cmd("ra00", 2'b10, 8'h00);
    cmd("rd_00b", 2'b11, 8'h00);
    read_out("rd_00b", 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
